// File: rtl/gpioemu_pkg.sv
// Shared constants and types for the GPIO-emulator bus master.
package gpioemu_pkg;

  // Peripheral register map.
  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;

  // Status register bit positions.
  localparam int STAT_DONE  = 1;
  localparam int STAT_VALID = 0;

  // Sequencer states; explicit codes keep the encoding stable for legacy probes.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_A1   = 4'd1,
    ST_WR_A2   = 4'd2,
    ST_WR_CTRL = 4'd3,
    ST_POLL    = 4'd4,
    ST_GAP     = 4'd5,
    ST_RD_W    = 4'd6,
    ST_RD_L    = 4'd7,
    ST_RESP    = 4'd8
  } state_t;

  // Phases of a single slave access.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } xfer_phase_t;

endpackage

// File: rtl/gpioemu_bus_master_sbus_xfer.sv
// One SETUP / STROBE / HOLD access on the slave register bus.
// A start presented while idle or during HOLD begins SETUP on the next cycle,
// so back-to-back accesses run with no dead cycle between them.
module sbus_xfer
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  xfer_phase_t      phase;
  logic [CNT_W-1:0] strobe_cnt;
  logic             we_q;

  // done marks the HOLD cycle; read data is taken at the edge that ends it.
  assign done  = (phase == PH_HOLD);
  assign rdata = sdata_rd;

  // Phase sequencer with registered bus outputs; reset drops strobes at once.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase      <= PH_IDLE;
      strobe_cnt <= '0;
      we_q       <= 1'b0;
      saddress   <= '0;
      swr        <= 1'b0;
      srd        <= 1'b0;
      sdata_wr   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (phase)
        PH_SETUP: begin
          phase      <= PH_STROBE;
          strobe_cnt <= CNT_W'(STROBE_CYCLES - 1);
          swr        <= we_q;
          srd        <= ~we_q;
        end
        PH_STROBE: begin
          if (strobe_cnt == '0) begin
            phase <= PH_HOLD;
            swr   <= 1'b0;
            srd   <= 1'b0;
          end else begin
            strobe_cnt <= strobe_cnt - 1'b1;
          end
        end
        default: begin
          if (start) begin
            phase    <= PH_SETUP;
            we_q     <= we;
            saddress <= addr;
            sdata_wr <= we ? wdata : '0;
          end else begin
            phase    <= PH_IDLE;
            saddress <= '0;
            sdata_wr <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/gpioemu_bus_master.sv
// Command/response front end that sequences a multiply on the GPIO-emulator
// peripheral: write A1, A2, start, poll status, read W and L, return result.
module gpioemu_bus_master
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_GAP      = 4,
  parameter int POLL_MAX      = 1024
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_w,
  output logic [5:0]  rsp_ones,
  output logic        rsp_overflow,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  localparam int POLL_CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [POLL_CNT_W-1:0] POLL_LAST = POLL_CNT_W'(POLL_MAX - 1);

  state_t                state, state_d;
  logic [23:0]           a2_q;
  logic [POLL_CNT_W-1:0] poll_cnt;
  logic [GAP_W-1:0]      gap_cnt;

  logic        x_start, x_we, x_done;
  logic [15:0] x_addr;
  logic [31:0] x_wdata, x_rdata;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  sbus_xfer #(.STROBE_CYCLES(STROBE_CYCLES)) u_xfer (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (x_start),
    .we       (x_we),
    .addr     (x_addr),
    .wdata    (x_wdata),
    .done     (x_done),
    .rdata    (x_rdata),
    .saddress (saddress),
    .swr      (swr),
    .srd      (srd),
    .sdata_wr (sdata_wr),
    .sdata_rd (sdata_rd)
  );

  // Next state and the next access request, issued as the current one ends.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d = state;
    x_start = 1'b0;
    x_we    = 1'b0;
    x_addr  = '0;
    x_wdata = '0;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        // A1 goes straight into the access register; only A2 needs holding.
        x_start = 1'b1; x_we = 1'b1; x_addr = ADDR_A1; x_wdata = {8'd0, cmd_a1};
        state_d = ST_WR_A1;
      end
      ST_WR_A1: if (x_done) begin
        x_start = 1'b1; x_we = 1'b1; x_addr = ADDR_A2; x_wdata = {8'd0, a2_q};
        state_d = ST_WR_A2;
      end
      ST_WR_A2: if (x_done) begin
        x_start = 1'b1; x_we = 1'b1; x_addr = ADDR_CTRL;
        state_d = ST_WR_CTRL;
      end
      ST_WR_CTRL: if (x_done) begin
        x_start = 1'b1; x_addr = ADDR_CTRL;
        state_d = ST_POLL;
      end
      ST_POLL: if (x_done) begin
        if (x_rdata[STAT_DONE]) begin
          x_start = 1'b1; x_addr = ADDR_W;
          state_d = ST_RD_W;
        end else if (poll_cnt == POLL_LAST) begin
          state_d = ST_RESP;
        end else if (POLL_GAP == 0) begin
          x_start = 1'b1; x_addr = ADDR_CTRL;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: if (gap_cnt == '0) begin
        x_start = 1'b1; x_addr = ADDR_CTRL;
        state_d = ST_POLL;
      end
      ST_RD_W: if (x_done) begin
        x_start = 1'b1; x_addr = ADDR_L;
        state_d = ST_RD_L;
      end
      ST_RD_L: if (x_done) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand, counter and response registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= ST_IDLE;
      a2_q         <= '0;
      poll_cnt     <= '0;
      gap_cnt      <= '0;
      rsp_w        <= '0;
      rsp_ones     <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          a2_q         <= cmd_a2;
          poll_cnt     <= '0;
          rsp_w        <= '0;
          rsp_ones     <= '0;
          rsp_overflow <= 1'b0;
          rsp_timeout  <= 1'b0;
        end
        ST_POLL: if (x_done) begin
          if (x_rdata[STAT_DONE]) begin
            rsp_overflow <= ~x_rdata[STAT_VALID];
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            gap_cnt  <= GAP_W'(POLL_GAP - 1);
            if (poll_cnt == POLL_LAST) begin
              rsp_timeout  <= 1'b1;
              rsp_w        <= '0;
              rsp_ones     <= '0;
              rsp_overflow <= 1'b0;
            end
          end
        end
        ST_GAP:  if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        ST_RD_W: if (x_done) rsp_w <= x_rdata;
        ST_RD_L: if (x_done) rsp_ones <= x_rdata[5:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Directed bench: instance 0 uses default parameters, instance 1 uses
// STROBE_CYCLES=3, POLL_GAP=4, POLL_MAX=4. A behavioural slave answers each.
module tb_gpioemu_bus_master;
  import gpioemu_pkg::*;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [23:0] cmd_a1 [2];
  logic [23:0] cmd_a2 [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_w [2];
  logic [5:0]  rsp_ones [2];
  logic        rsp_overflow [2];
  logic        rsp_timeout [2];
  logic        busy [2];
  logic [15:0] saddress [2];
  logic        swr [2];
  logic        srd [2];
  logic [31:0] sdata_wr [2];
  logic [31:0] sdata_rd [2];

  gpioemu_bus_master u_dut0 (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_a1(cmd_a1[0]), .cmd_a2(cmd_a2[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_w(rsp_w[0]), .rsp_ones(rsp_ones[0]),
    .rsp_overflow(rsp_overflow[0]), .rsp_timeout(rsp_timeout[0]), .busy(busy[0]),
    .saddress(saddress[0]), .swr(swr[0]), .srd(srd[0]),
    .sdata_wr(sdata_wr[0]), .sdata_rd(sdata_rd[0])
  );

  gpioemu_bus_master #(.STROBE_CYCLES(3), .POLL_GAP(4), .POLL_MAX(4)) u_dut1 (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_a1(cmd_a1[1]), .cmd_a2(cmd_a2[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_w(rsp_w[1]), .rsp_ones(rsp_ones[1]),
    .rsp_overflow(rsp_overflow[1]), .rsp_timeout(rsp_timeout[1]), .busy(busy[1]),
    .saddress(saddress[1]), .swr(swr[1]), .srd(srd[1]),
    .sdata_wr(sdata_wr[1]), .sdata_rd(sdata_rd[1])
  );

  // Slave model configuration: first n_pre status reads return st_pre, then st_post.
  int          n_pre [2];
  logic [1:0]  st_pre [2];
  logic [1:0]  st_post [2];
  logic [31:0] w_val [2];
  logic [31:0] l_val [2];

  // Bus monitor state.
  logic        mon_clr [2];
  int          st_cnt [2], w_cnt [2], l_cnt [2], wr_cnt [2];
  int          both_cnt [2], addr_err [2], rdwr_err [2];
  int          run [2], run_min [2], run_max [2];
  int          idle_run [2], gap_min [2], gap_max [2];
  logic        stb_prev [2], srd_prev [2], swr_prev [2];
  logic [15:0] addr_prev [2];
  logic [15:0] wr_addr [2][8];
  logic [31:0] wr_data [2][8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave read data, decoded from the address currently on the bus.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      case (saddress[i])
        ADDR_CTRL: sdata_rd[i] = {30'd0, (st_cnt[i] <= n_pre[i]) ? st_pre[i] : st_post[i]};
        ADDR_W:    sdata_rd[i] = w_val[i];
        ADDR_L:    sdata_rd[i] = l_val[i];
        default:   sdata_rd[i] = 32'd0;
      endcase
    end
  end

  // Bus monitor, sampled on the falling edge away from output updates.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_clr[i]) begin
        st_cnt[i] <= 0; w_cnt[i] <= 0; l_cnt[i] <= 0; wr_cnt[i] <= 0;
        both_cnt[i] <= 0; addr_err[i] <= 0; rdwr_err[i] <= 0;
        run[i] <= 0; run_min[i] <= 999; run_max[i] <= 0;
        idle_run[i] <= 0; gap_min[i] <= 999; gap_max[i] <= 0;
        stb_prev[i] <= 1'b0; srd_prev[i] <= 1'b0; swr_prev[i] <= 1'b0;
        addr_prev[i] <= '0;
      end else begin
        if (srd[i] && swr[i]) both_cnt[i] <= both_cnt[i] + 1;
        if (srd[i] && sdata_wr[i] != 0) rdwr_err[i] <= rdwr_err[i] + 1;
        if ((srd[i] || swr[i] || stb_prev[i]) && saddress[i] != addr_prev[i])
          addr_err[i] <= addr_err[i] + 1;
        if (srd[i] || swr[i]) begin
          run[i] <= run[i] + 1;
        end else if (run[i] != 0) begin
          if (run[i] < run_min[i]) run_min[i] <= run[i];
          if (run[i] > run_max[i]) run_max[i] <= run[i];
          run[i] <= 0;
        end
        if (srd[i] && !srd_prev[i]) begin
          if (saddress[i] == ADDR_CTRL) st_cnt[i] <= st_cnt[i] + 1;
          if (saddress[i] == ADDR_W)    w_cnt[i]  <= w_cnt[i] + 1;
          if (saddress[i] == ADDR_L)    l_cnt[i]  <= l_cnt[i] + 1;
        end
        if (swr[i] && !swr_prev[i] && wr_cnt[i] < 8) begin
          wr_addr[i][wr_cnt[i]] <= saddress[i];
          wr_data[i][wr_cnt[i]] <= sdata_wr[i];
          wr_cnt[i] <= wr_cnt[i] + 1;
        end
        if (busy[i] && saddress[i] == 0 && !srd[i] && !swr[i]) begin
          idle_run[i] <= idle_run[i] + 1;
        end else begin
          if (saddress[i] != 0 && idle_run[i] != 0) begin
            if (idle_run[i] < gap_min[i]) gap_min[i] <= idle_run[i];
            if (idle_run[i] > gap_max[i]) gap_max[i] <= idle_run[i];
          end
          idle_run[i] <= 0;
        end
        stb_prev[i]  <= srd[i] | swr[i];
        srd_prev[i]  <= srd[i];
        swr_prev[i]  <= swr[i];
        addr_prev[i] <= saddress[i];
      end
    end
  end

  task automatic set_slave(input int i, input int pre_n, input logic [1:0] pre,
                           input logic [1:0] post, input logic [31:0] w, input logic [31:0] l);
    n_pre[i] = pre_n; st_pre[i] = pre; st_post[i] = post; w_val[i] = w; l_val[i] = l;
  endtask

  task automatic clear_mon(input int i);
    @(posedge clk); mon_clr[i] = 1'b1;
    @(posedge clk); mon_clr[i] = 1'b0;
  endtask

  // Issue one command and count falling edges until rsp_valid (bounded).
  task automatic run_cmd(input int i, input logic [23:0] a1, input logic [23:0] a2, output int lat);
    clear_mon(i);
    @(negedge clk);
    cmd_a1[i] = a1; cmd_a2[i] = a2; cmd_valid[i] = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      cmd_valid[i] = 1'b0;
      lat++;
    end while (!rsp_valid[i] && lat < 4000);
  endtask

  task automatic accept(input int i, input string tag);
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    check({tag, "_cmd_ready_after"}, cmd_ready[i], 1'b1);
    check({tag, "_rsp_valid_after"}, rsp_valid[i], 1'b0);
  endtask

  initial begin
    int lat;
    int bp_err;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_a1[i] = '0; cmd_a2[i] = '0; rsp_ready[i] = 1'b0;
      mon_clr[i] = 1'b0;
      set_slave(i, 0, 2'b00, 2'b11, 32'd0, 32'd0);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready[0], 1'b1);
    check("rst_rsp_valid", rsp_valid[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_bus", {saddress[0], 14'd0, swr[0], srd[0]}, 32'd0);
    check("rst_rsp_w", rsp_w[0], 32'd0);
    check("rst_cmd_ready1", cmd_ready[1], 1'b1);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic multiply: three status reads, gaps of 4.
    set_slave(0, 2, 2'b01, 2'b11, 32'h0000_000F, 32'hFFFF_FFC4);
    run_cmd(0, 24'd3, 24'd5, lat);
    check("basic_latency", lat, 41);
    check("basic_rsp_w", rsp_w[0], 32'h0000_000F);
    check("basic_rsp_ones", rsp_ones[0], 6'd4);
    check("basic_overflow", rsp_overflow[0], 1'b0);
    check("basic_timeout", rsp_timeout[0], 1'b0);
    check("basic_status_reads", st_cnt[0], 3);
    check("basic_w_reads", w_cnt[0], 1);
    check("basic_l_reads", l_cnt[0], 1);
    check("basic_writes", wr_cnt[0], 3);
    check("basic_wr0_addr", wr_addr[0][0], ADDR_A1);
    check("basic_wr1_addr", wr_addr[0][1], ADDR_A2);
    check("basic_wr2_addr", wr_addr[0][2], ADDR_CTRL);
    check("basic_wr0_data", wr_data[0][0], 32'd3);
    check("basic_wr1_data", wr_data[0][1], 32'd5);
    check("basic_wr2_data", wr_data[0][2], 32'd0);
    check("basic_strobe_min", run_min[0], 2);
    check("basic_strobe_max", run_max[0], 2);
    check("basic_gap_min", gap_min[0], 4);
    check("basic_gap_max", gap_max[0], 4);
    check("basic_rd_wr_both", both_cnt[0], 0);
    check("basic_addr_stable", addr_err[0], 0);
    check("basic_wdata_on_read", rdwr_err[0], 0);
    accept(0, "basic");

    // Overflow: status done without valid.
    set_slave(0, 0, 2'b00, 2'b10, 32'hFE00_0001, 32'h0000_0008);
    run_cmd(0, 24'hFF_FFFF, 24'hFF_FFFF, lat);
    check("ovf_latency", lat, 25);
    check("ovf_rsp_w", rsp_w[0], 32'hFE00_0001);
    check("ovf_rsp_ones", rsp_ones[0], 6'd8);
    check("ovf_overflow", rsp_overflow[0], 1'b1);
    check("ovf_timeout", rsp_timeout[0], 1'b0);
    check("ovf_wr0_data", wr_data[0][0], 32'h00FF_FFFF);
    accept(0, "ovf");

    // Backpressure: response held, stray command pulses ignored.
    set_slave(0, 0, 2'b00, 2'b11, 32'd63, 32'd6);
    run_cmd(0, 24'd7, 24'd9, lat);
    bp_err = 0;
    for (int c = 0; c < 10; c++) begin
      cmd_valid[0] = c[0];
      cmd_a1[0] = 24'(c + 100);
      @(negedge clk);
      if (rsp_w[0] != 32'd63 || rsp_ones[0] != 6'd6 || !rsp_valid[0] || cmd_ready[0] ||
          rsp_overflow[0] || rsp_timeout[0]) bp_err++;
    end
    cmd_valid[0] = 1'b0;
    check("bp_stable", bp_err, 0);
    check("bp_writes", wr_cnt[0], 3);
    accept(0, "bp");
    repeat (3) @(negedge clk);
    check("bp_no_stray_cmd", busy[0], 1'b0);

    // Reset during the strobe of the A2 write, then a clean command.
    set_slave(0, 0, 2'b00, 2'b11, 32'h0000_000F, 32'h0000_0004);
    clear_mon(0);
    @(negedge clk);
    cmd_a1[0] = 24'd3; cmd_a2[0] = 24'd5; cmd_valid[0] = 1'b1;
    @(posedge clk);
    repeat (6) begin
      @(negedge clk);
      cmd_valid[0] = 1'b0;
    end
    check("rst_mid_swr_before", swr[0], 1'b1);
    check("rst_mid_addr_before", saddress[0], ADDR_A2);
    #1 n_reset = 1'b0;
    #1;
    check("rst_mid_swr", swr[0], 1'b0);
    check("rst_mid_addr", saddress[0], 16'd0);
    check("rst_mid_cmd_ready", cmd_ready[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("rst_rel_cmd_ready", cmd_ready[0], 1'b1);
    run_cmd(0, 24'd3, 24'd5, lat);
    check("rst_next_latency", lat, 25);
    check("rst_next_rsp_w", rsp_w[0], 32'h0000_000F);
    check("rst_next_ones", rsp_ones[0], 6'd4);
    check("rst_next_writes", wr_cnt[0], 3);
    check("rst_next_wr1_addr", wr_addr[0][1], ADDR_A2);
    check("rst_next_wr1_data", wr_data[0][1], 32'd5);
    accept(0, "rst_next");

    // Timeout and bus timing on instance 1: status stuck at valid-only.
    set_slave(1, 1000, 2'b01, 2'b01, 32'h1234_5678, 32'h0000_0011);
    run_cmd(1, 24'd2, 24'd4, lat);
    check("to_latency", lat, 48);
    check("to_timeout", rsp_timeout[1], 1'b1);
    check("to_rsp_w", rsp_w[1], 32'd0);
    check("to_rsp_ones", rsp_ones[1], 6'd0);
    check("to_overflow", rsp_overflow[1], 1'b0);
    check("to_status_reads", st_cnt[1], 4);
    check("to_w_reads", w_cnt[1], 0);
    check("to_l_reads", l_cnt[1], 0);
    check("to_strobe_min", run_min[1], 3);
    check("to_strobe_max", run_max[1], 3);
    check("to_gap_min", gap_min[1], 4);
    check("to_gap_max", gap_max[1], 4);
    check("to_rd_wr_both", both_cnt[1], 0);
    check("to_addr_stable", addr_err[1], 0);
    accept(1, "to");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
